psi_input_collector: RTL

Upstream loader for the bitonic PSI core. It accepts party set elements one per cycle over a valid/ready stream and packs them into the flat N*K*W input bus the PSI core consumes. It then holds that bus stable behind an out_valid/out_ready handshake. It also checks per-party ascending order and flags violations.

---
 rtl/psi_pkg.sv | 26 ++
 rtl/psi_order_check.sv | 37 +++
 rtl/psi_input_collector.sv | 117 +++++++++++
 3 files changed

// File: rtl/psi_pkg.sv
// Shared definitions for the PSI input collector and the PSI core wrappers:
// the loader state encoding and the index-width helpers.
package psi_pkg;

    localparam logic ST_LOAD = 1'b0;
    localparam logic ST_FULL = 1'b1;

    typedef enum logic {
        LOAD = ST_LOAD,
        FULL = ST_FULL
    } state_t;

    // A width of at least one bit, so that a count of 1 still yields a legal vector.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int party_idx_w(input int n_parties);
        return clog2_min1(n_parties);
    endfunction

    function automatic int elem_idx_w(input int k_elems);
        return clog2_min1(k_elems);
    endfunction

endpackage

// File: rtl/psi_order_check.sv
// Strict-ascending checker for one party's stream. It keeps the previous accepted
// element and raises a sticky error that is cleared on batch handoff.
module psi_order_check #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_accept,
    input  logic         i_first,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_err
);

    logic [W-1:0] r_prev;
    logic         r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_err  <= 1'b0;
        end else begin
            if (i_accept) begin
                r_prev <= i_data;
            end
            // The first element of a party has no predecessor, so the stale r_prev is ignored.
            if (i_clear) begin
                r_err <= 1'b0;
            end else if (i_accept && !i_first && (i_data <= r_prev)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/psi_input_collector.sv
// Packs a stream of N*K set elements into the flat PSI input bus and holds it behind a
// valid/ready handoff. Define PSI_ORDER_CHECK_EN to build in the ascending-order checker.
module psi_input_collector
    import psi_pkg::*;
#(
    parameter int W = 16,
    parameter int K = 16,
    parameter int N = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W*K*N-1:0]           p_input,
    output logic [party_idx_w(N)-1:0]  party_idx,
    output logic                       order_err
);

    localparam int PW = party_idx_w(N);
    localparam int KW = elem_idx_w(K);

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_party;
    logic [KW-1:0]   r_elem;
    logic            w_accept;
    logic            w_handoff;
    logic            w_last_elem;
    logic            w_last_slot;

    assign w_accept    = in_valid && (r_state == LOAD);
    assign w_handoff   = out_ready && (r_state == FULL);
    assign w_last_elem = (r_elem == KW'(K - 1));
    assign w_last_slot = w_last_elem && (r_party == PW'(N - 1));
    assign party_idx   = r_party;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (w_accept && w_last_slot) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = LOAD;
                end
            end
            default: ;
        endcase
    end

    // The counters wrap to zero on the final accept, so FULL always starts with them cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_party <= '0;
            r_elem  <= '0;
        end else if (w_accept) begin
            if (w_last_elem) begin
                r_elem  <= '0;
                r_party <= (r_party == PW'(N - 1)) ? '0 : r_party + PW'(1);
            end else begin
                r_elem <= r_elem + KW'(1);
            end
        end else if (w_handoff) begin
            r_party <= '0;
            r_elem  <= '0;
        end
    end

    for (genvar gi = 0; gi < N * K; gi++) begin : g_slot
        logic [W-1:0] r_slot;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_slot <= '0;
            end else if (w_accept && (r_party == PW'(gi / K)) && (r_elem == KW'(gi % K))) begin
                r_slot <= in_data;
            end
        end

        assign p_input[gi*W +: W] = r_slot;
    end

`ifdef PSI_ORDER_CHECK_EN
    psi_order_check #(
        .W (W)
    ) u_order_check (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_accept (w_accept),
        .i_first  (r_elem == '0),
        .i_clear  (w_handoff),
        .i_data   (in_data),
        .o_err    (order_err)
    );
`else
    assign order_err = 1'b0;
`endif

endmodule
